switch_event_gen: RTL

- Downstream consumer of a debounced switch line.
- Converts the clean level into single-cycle press, release and auto-repeat event pulses, plus a held flag.
- Paddle-control logic steps the paddle once per press, then at a steady rate while the button is held.
- Sits between the switch debouncer output and the game/paddle state logic, all in one clock domain.

---
 rtl/switch_event_pkg.sv | 20 ++
 rtl/switch_event_if.sv | 30 +++
 rtl/event_interval_counter.sv | 30 +++
 rtl/switch_event_gen.sv | 129 ++++++++++++
 4 files changed

// File: rtl/switch_event_pkg.sv
// Shared types and defaults for the switch event generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package switch_event_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  // 0.5 s first-repeat delay and 0.1 s repeat period at 25 MHz
  localparam int DEF_REPEAT_DELAY  = 12500000;
  localparam int DEF_REPEAT_PERIOD = 2500000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/switch_event_if.sv
// Debounced switch level in, press/release/repeat pulses and held flag out.
// Latency: n/a (wiring only).
// Backpressure: none; events are fire-and-forget single-cycle pulses.
interface switch_event_if;

  logic sw_i;
  logic press_o;
  logic release_o;
  logic repeat_o;
  logic held_o;

  // Source of the switch level, consumer of the events
  modport master (
    output sw_i,
    input  press_o,
    input  release_o,
    input  repeat_o,
    input  held_o
  );

  // Event generator side
  modport slave (
    input  sw_i,
    output press_o,
    output release_o,
    output repeat_o,
    output held_o
  );

endinterface

// File: rtl/event_interval_counter.sv
// Clearable up-counter with a terminal-count compare against a selectable limit.
// Latency: tc_o is combinational from the registered count.
// Backpressure: none; counts whenever enabled.
module event_interval_counter #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic         tc_o
);

  logic [W-1:0] count_q;

  // Count register: clear has priority over increment
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + W'(1);
    end
  end

  assign tc_o = (count_q == limit_i);

endmodule

// File: rtl/switch_event_gen.sv
// Turns a debounced switch level into press/release/auto-repeat pulses and a held flag.
// Latency: events 1 cycle after the sampled edge/terminal count (+2 with SWITCH_EVENT_SYNC_EN).
// Backpressure: none; pulses are single-cycle and never overlap.
module switch_event_gen
  import switch_event_pkg::*;
#(
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input logic          clk_i,
  input logic          rst_n_i,
  switch_event_if.slave bus
);

  localparam int CNT_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [CNT_W-1:0] DLY_LIM = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LIM = CNT_W'(REPEAT_PERIOD - 1);

  logic sw_lvl;

`ifdef SWITCH_EVENT_SYNC_EN
  logic sw_meta_q;
  logic sw_sync_q;

  // Two-flop synchronizer so an asynchronous source can be wired straight in
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sw_meta_q <= 1'b0;
      sw_sync_q <= 1'b0;
    end else begin
      sw_meta_q <= bus.sw_i;
      sw_sync_q <= sw_meta_q;
    end
  end

  assign sw_lvl = sw_sync_q;
`else
  assign sw_lvl = bus.sw_i;
`endif

  logic   sw_prev_q;
  logic   rise;
  logic   fall;
  state_t state_q, state_d;
  logic   press_q, press_d;
  logic   rel_q, rel_d;
  logic   rpt_q, rpt_d;
  logic   held_q, held_d;
  logic   cnt_clr;
  logic   cnt_en;
  logic   cnt_tc;
  logic [CNT_W-1:0] cnt_lim;

  assign rise = sw_lvl & ~sw_prev_q;
  assign fall = ~sw_lvl & sw_prev_q;

  // The delay and the period share one counter; the limit follows the state
  assign cnt_lim = (state_q == ST_REPEAT) ? PER_LIM : DLY_LIM;

  event_interval_counter #(
    .W (CNT_W)
  ) u_interval (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .limit_i (cnt_lim),
    .tc_o    (cnt_tc)
  );

  // State, edge-history and registered output flops
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      sw_prev_q <= 1'b0;
      press_q   <= 1'b0;
      rel_q     <= 1'b0;
      rpt_q     <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sw_prev_q <= sw_lvl;
      press_q   <= press_d;
      rel_q     <= rel_d;
      rpt_q     <= rpt_d;
      held_q    <= held_d;
    end
  end

  // Next state and next outputs; a release always beats a coincident terminal count
  always_comb begin
    state_d = state_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    rpt_d   = 1'b0;
    cnt_clr = 1'b1;
    cnt_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          press_d = 1'b1;
          state_d = ST_DELAY;
        end
      end
      ST_DELAY, ST_REPEAT: begin
        if (fall) begin
          rel_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_tc) begin
          rpt_d   = 1'b1;
          state_d = ST_REPEAT;
        end else begin
          cnt_clr = 1'b0;
          cnt_en  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    held_d = (state_d != ST_IDLE);
  end

  assign bus.press_o   = press_q;
  assign bus.release_o = rel_q;
  assign bus.repeat_o  = rpt_q;
  assign bus.held_o    = held_q;

endmodule
